// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake bundle for decode_stage.
//   slave  modport : used by decode_stage (consumes instr_i/pc_i, produces decoded entry)
//   master modport : used by the surrounding pipeline / testbench
// Signals:
//   flush_i, in_valid_i, in_ready_o, instr_i[XLEN], pc_i[PC_WIDTH]   fetch side
//   out_valid_o, out_ready_i, pc_o, alu_op_o, lis_op_o, br_op_o,
//   data_origin_o, imm_o, rs1_o, rs2_o, rd_o, reg_write_o, mem_write_o,
//   is_load_o, is_branch_o, illegal_o                               execute side
interface decode_stage_if #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned PC_WIDTH       = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
);
  localparam int unsigned ALU_OP_WIDTH      = 4;
  localparam int unsigned LIS_OP_WIDTH      = 4;
  localparam int unsigned BR_OP_WIDTH       = 3;
  localparam int unsigned DATA_ORIGIN_WIDTH = 2;

  logic                         flush_i;
  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [XLEN-1:0]              instr_i;
  logic [PC_WIDTH-1:0]          pc_i;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic [PC_WIDTH-1:0]          pc_o;
  logic [ALU_OP_WIDTH-1:0]      alu_op_o;
  logic [LIS_OP_WIDTH-1:0]      lis_op_o;
  logic [BR_OP_WIDTH-1:0]       br_op_o;
  logic [DATA_ORIGIN_WIDTH-1:0] data_origin_o;
  logic [XLEN-1:0]              imm_o;
  logic [REG_ADDR_WIDTH-1:0]    rs1_o;
  logic [REG_ADDR_WIDTH-1:0]    rs2_o;
  logic [REG_ADDR_WIDTH-1:0]    rd_o;
  logic                         reg_write_o;
  logic                         mem_write_o;
  logic                         is_load_o;
  logic                         is_branch_o;
  logic                         illegal_o;

  modport master (
    output flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_o, alu_op_o, lis_op_o, br_op_o,
           data_origin_o, imm_o, rs1_o, rs2_o, rd_o, reg_write_o,
           mem_write_o, is_load_o, is_branch_o, illegal_o
  );

  modport slave (
    input  flush_i, in_valid_i, instr_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, alu_op_o, lis_op_o, br_op_o,
           data_origin_o, imm_o, rs1_o, rs2_o, rd_o, reg_write_o,
           mem_write_o, is_load_o, is_branch_o, illegal_o
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage with valid/ready on both sides,
// load-use bubble insertion, flush, illegal flagging and rd==x0 write suppression.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   decode_stage_if.slave (fetch handshake in, decoded entry out)
//   stat_decoded_o, stat_bubbles_o  (only when DECODE_STATS_EN is defined)
// Encodings:
//   alu_op      : ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9
//   lis_op      : NONE0 LB1 LH2 LW3 LBU4 LHU5 SB6 SH7 SW8
//   br_op       : NONE0 EQ1 NE2 LT3 GE4 JAL5 JALR6
//   data_origin : REG_REG0 REG_IMM1 PC_IMM2
module decode_stage #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned PC_WIDTH       = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned HAZARD_CHECK   = 1
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]   stat_decoded_o,
  output logic [31:0]   stat_bubbles_o
`endif
);
  localparam int unsigned ALU_OP_WIDTH      = 4;
  localparam int unsigned LIS_OP_WIDTH      = 4;
  localparam int unsigned BR_OP_WIDTH       = 3;
  localparam int unsigned DATA_ORIGIN_WIDTH = 2;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4,
    ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR  = 4'd8, ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [LIS_OP_WIDTH-1:0] {
    LIS_NONE = 4'd0, LIS_LB = 4'd1, LIS_LH = 4'd2, LIS_LW = 4'd3, LIS_LBU = 4'd4,
    LIS_LHU  = 4'd5, LIS_SB = 4'd6, LIS_SH = 4'd7, LIS_SW = 4'd8
  } lis_op_e;

  typedef enum logic [BR_OP_WIDTH-1:0] {
    BR_NONE = 3'd0, BR_EQ = 3'd1, BR_NE = 3'd2, BR_LT = 3'd3, BR_GE = 3'd4,
    BR_JAL  = 3'd5, BR_JALR = 3'd6
  } br_op_e;

  typedef enum logic [DATA_ORIGIN_WIDTH-1:0] {
    ORG_REG_REG = 2'd0, ORG_REG_IMM = 2'd1, ORG_PC_IMM = 2'd2
  } data_origin_e;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111, OPC_AUIPC  = 7'b0010111, OPC_JAL   = 7'b1101111,
    OPC_JALR   = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD  = 7'b0000011,
    OPC_STORE  = 7'b0100011, OPC_OP_IMM = 7'b0010011, OPC_OP    = 7'b0110011,
    OPC_FENCE  = 7'b0001111, OPC_SYSTEM = 7'b1110011
  } opcode_e;

  function automatic alu_op_e alu_from_f3(input logic [2:0] f, input logic alt);
    case (f)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [31:0]               ins;
  logic [2:0]                f3;
  logic [REG_ADDR_WIDTH-1:0] rs1_f, rs2_f, rd_f;
  logic [XLEN-1:0]           imm_i, imm_s, imm_b, imm_u, imm_j;

  assign ins   = bus.instr_i[31:0];
  assign f3    = ins[14:12];
  assign rs1_f = REG_ADDR_WIDTH'(ins[19:15]);
  assign rs2_f = REG_ADDR_WIDTH'(ins[24:20]);
  assign rd_f  = REG_ADDR_WIDTH'(ins[11:7]);
  assign imm_i = XLEN'($signed(ins[31:20]));
  assign imm_s = XLEN'($signed({ins[31:25], ins[11:7]}));
  assign imm_b = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({ins[31:12], 12'h000}));
  assign imm_j = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));

  alu_op_e                   d_alu;
  lis_op_e                   d_lis;
  br_op_e                    d_br;
  data_origin_e              d_org;
  logic [XLEN-1:0]           d_imm;
  logic [REG_ADDR_WIDTH-1:0] d_rs1, d_rs2, d_rd;
  logic                      d_wr, d_mw, d_ld, d_isbr, d_ill;
  logic                      use_rs1, use_rs2;

  always_comb begin
    d_alu   = ALU_ADD;
    d_lis   = LIS_NONE;
    d_br    = BR_NONE;
    d_org   = ORG_REG_REG;
    d_imm   = '0;
    d_rs1   = '0;
    d_rs2   = '0;
    d_rd    = '0;
    d_wr    = 1'b0;
    d_mw    = 1'b0;
    d_ld    = 1'b0;
    d_isbr  = 1'b0;
    d_ill   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (ins[6:0])
      OPC_LUI: begin
        d_org = ORG_REG_IMM; d_imm = imm_u; d_rd = rd_f; d_wr = 1'b1;
      end
      OPC_AUIPC: begin
        d_org = ORG_PC_IMM; d_imm = imm_u; d_rd = rd_f; d_wr = 1'b1;
      end
      OPC_JAL: begin
        d_br = BR_JAL; d_org = ORG_PC_IMM; d_imm = imm_j; d_rd = rd_f;
        d_wr = 1'b1; d_isbr = 1'b1;
      end
      OPC_JALR: begin
        use_rs1 = 1'b1;
        d_br = BR_JALR; d_org = ORG_REG_IMM; d_imm = imm_i; d_rs1 = rs1_f;
        d_rd = rd_f; d_wr = 1'b1; d_isbr = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        d_imm = imm_b; d_rs1 = rs1_f; d_rs2 = rs2_f; d_isbr = 1'b1;
        // f3[2] selects ordered compare, f3[1] unsigned, f3[0] inverted sense
        case (f3)
          3'd0:    begin d_alu = ALU_SUB;  d_br = BR_EQ; end
          3'd1:    begin d_alu = ALU_SUB;  d_br = BR_NE; end
          3'd4:    begin d_alu = ALU_SLT;  d_br = BR_LT; end
          3'd5:    begin d_alu = ALU_SLT;  d_br = BR_GE; end
          3'd6:    begin d_alu = ALU_SLTU; d_br = BR_LT; end
          3'd7:    begin d_alu = ALU_SLTU; d_br = BR_GE; end
          default: d_ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        use_rs1 = 1'b1;
        d_org = ORG_REG_IMM; d_imm = imm_i; d_rs1 = rs1_f; d_rd = rd_f;
        d_wr = 1'b1; d_ld = 1'b1;
        case (f3)
          3'd0:    d_lis = LIS_LB;
          3'd1:    d_lis = LIS_LH;
          3'd2:    d_lis = LIS_LW;
          3'd4:    d_lis = LIS_LBU;
          3'd5:    d_lis = LIS_LHU;
          default: d_ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        d_org = ORG_REG_IMM; d_imm = imm_s; d_rs1 = rs1_f; d_rs2 = rs2_f; d_mw = 1'b1;
        case (f3)
          3'd0:    d_lis = LIS_SB;
          3'd1:    d_lis = LIS_SH;
          3'd2:    d_lis = LIS_SW;
          default: d_ill = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        use_rs1 = 1'b1;
        // bit30 is immediate data except for the shift-right pair
        d_alu = alu_from_f3(f3, (f3 == 3'd5) && ins[30]);
        d_org = ORG_REG_IMM; d_imm = imm_i; d_rs1 = rs1_f; d_rd = rd_f; d_wr = 1'b1;
      end
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        d_alu = alu_from_f3(f3, ins[30]);
        d_rs1 = rs1_f; d_rs2 = rs2_f; d_rd = rd_f; d_wr = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: d_ill = 1'b1;
    endcase
    // Illegal entries travel as inert NOPs carrying only the flag.
    if (d_ill) begin
      d_alu = ALU_ADD; d_lis = LIS_NONE; d_br = BR_NONE; d_org = ORG_REG_REG;
      d_imm = '0; d_rs1 = '0; d_rs2 = '0; d_rd = '0;
      d_wr = 1'b0; d_mw = 1'b0; d_ld = 1'b0; d_isbr = 1'b0;
    end
    if (d_rd == '0) d_wr = 1'b0;
  end

  logic                load_en, hazard, accept;
  logic [PC_WIDTH-1:0] pc_q;

  assign load_en = !bus.out_valid_o || bus.out_ready_i;
  assign hazard  = (HAZARD_CHECK != 0) && bus.out_valid_o && bus.is_load_o &&
                   (bus.rd_o != '0) && bus.in_valid_i &&
                   ((use_rs1 && (rs1_f == bus.rd_o)) || (use_rs2 && (rs2_f == bus.rd_o)));
  assign bus.in_ready_o = !rst && !bus.flush_i && !hazard && load_en;
  assign accept  = bus.in_valid_i && bus.in_ready_o;
  assign bus.pc_o = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid_o   <= 1'b0;
      pc_q              <= '0;
      bus.alu_op_o      <= '0;
      bus.lis_op_o      <= '0;
      bus.br_op_o       <= '0;
      bus.data_origin_o <= '0;
      bus.imm_o         <= '0;
      bus.rs1_o         <= '0;
      bus.rs2_o         <= '0;
      bus.rd_o          <= '0;
      bus.reg_write_o   <= 1'b0;
      bus.mem_write_o   <= 1'b0;
      bus.is_load_o     <= 1'b0;
      bus.is_branch_o   <= 1'b0;
      bus.illegal_o     <= 1'b0;
    end else if (bus.flush_i) begin
      bus.out_valid_o <= 1'b0;
    end else if (load_en) begin
      // A hazard blocks accept, so this path also produces the bubble.
      bus.out_valid_o <= accept;
      if (accept) begin
        pc_q              <= bus.pc_i;
        bus.alu_op_o      <= d_alu;
        bus.lis_op_o      <= d_lis;
        bus.br_op_o       <= d_br;
        bus.data_origin_o <= d_org;
        bus.imm_o         <= d_imm;
        bus.rs1_o         <= d_rs1;
        bus.rs2_o         <= d_rs2;
        bus.rd_o          <= d_rd;
        bus.reg_write_o   <= d_wr;
        bus.mem_write_o   <= d_mw;
        bus.is_load_o     <= d_ld;
        bus.is_branch_o   <= d_isbr;
        bus.illegal_o     <= d_ill;
      end
    end
  end

`ifdef DECODE_STATS_EN
  logic bubble;
  assign bubble = hazard && bus.out_ready_i && !bus.flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_decoded_o <= '0;
      stat_bubbles_o <= '0;
    end else begin
      if (accept) stat_decoded_o <= stat_decoded_o + 32'd1;
      if (bubble) stat_bubbles_o <= stat_bubbles_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3, A_SLTU = 4'd4,
                         A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_OR = 4'd8, A_AND = 4'd9;
  localparam logic [3:0] L_NONE = 4'd0, L_LB = 4'd1, L_LH = 4'd2, L_LW = 4'd3, L_LBU = 4'd4,
                         L_LHU = 4'd5, L_SB = 4'd6, L_SH = 4'd7, L_SW = 4'd8;
  localparam logic [2:0] B_NONE = 3'd0, B_EQ = 3'd1, B_NE = 3'd2, B_LT = 3'd3, B_GE = 3'd4,
                         B_JAL = 3'd5, B_JALR = 3'd6;
  localparam logic [1:0] O_RR = 2'd0, O_RI = 2'd1, O_PI = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu;
    logic [3:0]  lis;
    logic [2:0]  br;
    logic [1:0]  org;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        wr, mw, ld, isbr, ill;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32), .PC_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

`ifdef DECODE_STATS_EN
  logic [31:0] stat_decoded, stat_bubbles;
`endif

  decode_stage #(.XLEN(32), .PC_WIDTH(32), .REG_ADDR_WIDTH(5), .HAZARD_CHECK(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DECODE_STATS_EN
    ,
    .stat_decoded_o (stat_decoded),
    .stat_bubbles_o (stat_bubbles)
`endif
  );

  int unsigned n_total = 0, n_pass = 0, n_fail = 0;
  logic        m_valid = 1'b0;
  ent_t        m_e = '0;
  int unsigned m_dec = 0, m_bub = 0;
  logic [31:0] pc_cnt = 32'h1000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode from the ISA field rules, immediates built arithmetically.
  function automatic ent_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    ent_t e;
    logic [3:0] op_alu [8];
    logic [3:0] ld_lis [8];
    logic [3:0] st_lis [8];
    logic [2:0] br_cond [8];
    logic [3:0] br_alu [8];
    int f3, imm_i, imm_s, imm_b, imm_j;
    logic [6:0] opc;
    logic [4:0] rd;
    op_alu  = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    ld_lis  = '{L_LB, L_LH, L_LW, L_NONE, L_LBU, L_LHU, L_NONE, L_NONE};
    st_lis  = '{L_SB, L_SH, L_SW, L_NONE, L_NONE, L_NONE, L_NONE, L_NONE};
    br_cond = '{B_EQ, B_NE, B_NONE, B_NONE, B_LT, B_GE, B_LT, B_GE};
    br_alu  = '{A_SUB, A_SUB, A_ADD, A_ADD, A_SLT, A_SLT, A_SLTU, A_SLTU};
    e = '0;
    e.pc = pc;
    opc = w[6:0];
    rd  = w[11:7];
    f3  = int'(w[14:12]);
    imm_i = $signed(w) >>> 20;
    imm_s = (imm_i & -32) | int'(w[11:7]);
    imm_b = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    imm_j = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    case (opc)
      7'h37: begin e.org = O_RI; e.imm = w & 32'hFFFFF000; e.rd = rd; e.wr = (rd != 0); end
      7'h17: begin e.org = O_PI; e.imm = w & 32'hFFFFF000; e.rd = rd; e.wr = (rd != 0); end
      7'h6F: begin
        e.br = B_JAL; e.org = O_PI; e.imm = 32'(imm_j); e.rd = rd; e.wr = (rd != 0); e.isbr = 1'b1;
      end
      7'h67: begin
        e.br = B_JALR; e.org = O_RI; e.imm = 32'(imm_i); e.rs1 = w[19:15];
        e.rd = rd; e.wr = (rd != 0); e.isbr = 1'b1;
      end
      7'h63: begin
        if (f3 == 2 || f3 == 3) e.ill = 1'b1;
        else begin
          e.br = br_cond[f3]; e.alu = br_alu[f3]; e.org = O_RR; e.imm = 32'(imm_b);
          e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.isbr = 1'b1;
        end
      end
      7'h03: begin
        if (ld_lis[f3] == L_NONE) e.ill = 1'b1;
        else begin
          e.lis = ld_lis[f3]; e.org = O_RI; e.imm = 32'(imm_i); e.rs1 = w[19:15];
          e.rd = rd; e.wr = (rd != 0); e.ld = 1'b1;
        end
      end
      7'h23: begin
        if (f3 > 2) e.ill = 1'b1;
        else begin
          e.lis = st_lis[f3]; e.org = O_RI; e.imm = 32'(imm_s);
          e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.mw = 1'b1;
        end
      end
      7'h13: begin
        e.alu = (f3 == 5 && w[30]) ? A_SRA : op_alu[f3];
        e.org = O_RI; e.imm = 32'(imm_i); e.rs1 = w[19:15]; e.rd = rd; e.wr = (rd != 0);
      end
      7'h33: begin
        e.alu = op_alu[f3];
        if (w[30] && f3 == 0) e.alu = A_SUB;
        if (w[30] && f3 == 5) e.alu = A_SRA;
        e.org = O_RR; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = rd; e.wr = (rd != 0);
      end
      7'h0F, 7'h73: ;
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin
      e = '0;
      e.pc = pc;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [1:0] ref_uses(input logic [6:0] opc);
    logic u1, u2;
    u1 = opc inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    u2 = opc inside {7'h33, 7'h23, 7'h63};
    return {u1, u2};
  endfunction

  task automatic model_ready(output logic rdy, output logic haz);
    logic [31:0] w;
    logic [1:0]  u;
    w = bus.instr_i;
    u = ref_uses(w[6:0]);
    haz = m_valid && m_e.ld && (m_e.rd != 0) && bus.in_valid_i &&
          ((u[1] && w[19:15] == m_e.rd) || (u[0] && w[24:20] == m_e.rd));
    rdy = !bus.flush_i && !haz && (!m_valid || bus.out_ready_i);
  endtask

  task automatic model_step(input logic rdy, input logic haz);
    if (bus.flush_i) m_valid = 1'b0;
    else if (!m_valid || bus.out_ready_i) begin
      if (bus.in_valid_i && rdy) begin
        m_valid = 1'b1;
        m_e = ref_decode(bus.instr_i, bus.pc_i);
        m_dec++;
      end else begin
        if (haz) m_bub++;
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 64'(bus.out_valid_o), 64'(m_valid));
    if (m_valid) begin
      chk({tag, ".pc"},   64'(bus.pc_o),          64'(m_e.pc));
      chk({tag, ".alu"},  64'(bus.alu_op_o),      64'(m_e.alu));
      chk({tag, ".lis"},  64'(bus.lis_op_o),      64'(m_e.lis));
      chk({tag, ".br"},   64'(bus.br_op_o),       64'(m_e.br));
      chk({tag, ".org"},  64'(bus.data_origin_o), 64'(m_e.org));
      chk({tag, ".imm"},  64'(bus.imm_o),         64'(m_e.imm));
      chk({tag, ".rs1"},  64'(bus.rs1_o),         64'(m_e.rs1));
      chk({tag, ".rs2"},  64'(bus.rs2_o),         64'(m_e.rs2));
      chk({tag, ".rd"},   64'(bus.rd_o),          64'(m_e.rd));
      chk({tag, ".wr"},   64'(bus.reg_write_o),   64'(m_e.wr));
      chk({tag, ".mw"},   64'(bus.mem_write_o),   64'(m_e.mw));
      chk({tag, ".ld"},   64'(bus.is_load_o),     64'(m_e.ld));
      chk({tag, ".isbr"}, 64'(bus.is_branch_o),   64'(m_e.isbr));
      chk({tag, ".ill"},  64'(bus.illegal_o),     64'(m_e.ill));
    end
`ifdef DECODE_STATS_EN
    chk({tag, ".stat_dec"}, 64'(stat_decoded), 64'(m_dec));
    chk({tag, ".stat_bub"}, 64'(stat_bubbles), 64'(m_bub));
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, 64'(bus.out_valid_o), 64'd0);
    chk({tag, ".pc"},    64'(bus.pc_o),        64'd0);
    chk({tag, ".imm"},   64'(bus.imm_o),       64'd0);
    chk({tag, ".ctl"},   64'({bus.alu_op_o, bus.lis_op_o, bus.br_op_o, bus.data_origin_o}), 64'd0);
    chk({tag, ".regs"},  64'({bus.rs1_o, bus.rs2_o, bus.rd_o}), 64'd0);
    chk({tag, ".flags"}, 64'({bus.reg_write_o, bus.mem_write_o, bus.is_load_o,
                              bus.is_branch_o, bus.illegal_o}), 64'd0);
    chk({tag, ".in_ready"}, 64'(bus.in_ready_o), 64'd0);
  endtask

  // Entered #1 after a rising edge with inputs already driven.
  task automatic cycle(input string tag);
    logic rdy, haz;
    #1;
    model_ready(rdy, haz);
    chk({tag, ".in_ready"}, 64'(bus.in_ready_o), 64'(rdy));
    @(posedge clk);
    model_step(rdy, haz);
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
    bus.in_valid_i  = v;
    bus.instr_i     = w;
    bus.pc_i        = pc_cnt;
    bus.out_ready_i = rdy;
    bus.flush_i     = fl;
    pc_cnt          = pc_cnt + 4;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  opcs [12];
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F};
    w = $urandom;
    w[6:0]   = ($urandom_range(3, 0) == 0) ? 7'h03 : opcs[$urandom_range(11, 0)];
    w[11:7]  = 5'($urandom_range(3, 0));
    w[19:15] = 5'($urandom_range(3, 0));
    w[24:20] = 5'($urandom_range(3, 0));
    return w;
  endfunction

  initial begin
    int unsigned bub0, dec0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1 check_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    m_valid = 1'b0; m_e = '0; m_dec = 0; m_bub = 0;

    // lui x5, 0x12345
    drive(1'b1, 32'h123452B7, 1'b1, 1'b0);
    cycle("lui");
    chk("lui.imm_const", 64'(bus.imm_o), 64'h12345000);
    chk("lui.rd_const",  64'(bus.rd_o), 64'd5);
    chk("lui.wr_const",  64'(bus.reg_write_o), 64'd1);
    chk("lui.rs1_const", 64'(bus.rs1_o), 64'd0);

    // beq x0, x0, -4
    drive(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
    cycle("beq");
    chk("beq.isbr_const", 64'(bus.is_branch_o), 64'd1);
    chk("beq.imm_const",  64'(bus.imm_o), 64'hFFFFFFFC);
    chk("beq.alu_const",  64'(bus.alu_op_o), 64'(A_SUB));
    chk("beq.br_const",   64'(bus.br_op_o), 64'(B_EQ));
    chk("beq.wr_const",   64'(bus.reg_write_o), 64'd0);

    // lw x2,0(x1) then add x3,x2,x1: one bubble
    bub0 = m_bub; dec0 = m_dec;
    drive(1'b1, 32'h0000A103, 1'b1, 1'b0);
    cycle("lw");
    drive(1'b1, 32'h001101B3, 1'b1, 1'b0);
    bus.pc_i = 32'h2000;
    #1 chk("lu.in_ready_const", 64'(bus.in_ready_o), 64'd0);
    @(posedge clk); #1;
    chk("lu.bubble_const", 64'(bus.out_valid_o), 64'd0);
    m_valid = 1'b0; m_bub++;
    cycle("add");
    chk("add.rd_const", 64'(bus.rd_o), 64'd3);
    chk("add.pc_const", 64'(bus.pc_o), 64'h2000);
`ifdef DECODE_STATS_EN
    chk("lu.stat_bub_const", 64'(stat_bubbles), 64'(bub0 + 1));
    chk("lu.stat_dec_const", 64'(stat_decoded), 64'(dec0 + 2));
`endif

    // addi x0,x0,5 and an all-ones word
    drive(1'b1, 32'h00500013, 1'b1, 1'b0);
    cycle("addi_x0");
    chk("addi_x0.wr_const",  64'(bus.reg_write_o), 64'd0);
    chk("addi_x0.ill_const", 64'(bus.illegal_o), 64'd0);
    drive(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    cycle("ones");
    chk("ones.ill_const", 64'(bus.illegal_o), 64'd1);
    chk("ones.wr_mw_const", 64'({bus.reg_write_o, bus.mem_write_o}), 64'd0);

    // backpressure hold, then flush
    drive(1'b1, 32'h123452B7, 1'b1, 1'b0);
    cycle("hold_fill");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h00100093, 1'b0, 1'b0);
      cycle("hold");
      chk("hold.imm_const", 64'(bus.imm_o), 64'h12345000);
    end
    drive(1'b1, 32'h00100093, 1'b0, 1'b1);
    cycle("flush");
    chk("flush.valid_const", 64'(bus.out_valid_o), 64'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    cycle("post_flush");

    // asynchronous reset with a valid entry held
    drive(1'b1, 32'h0000A103, 1'b0, 1'b0);
    cycle("pre_arst");
    #2 rst = 1'b1;
    #1 check_zero("arst");
    @(posedge clk);
    #1 rst = 1'b0;
    m_valid = 1'b0; m_e = '0; m_dec = 0; m_bub = 0;

    // randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(9, 0) < 7, rand_instr(), $urandom_range(9, 0) < 7,
            $urandom_range(19, 0) == 0);
      cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
